// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit adder that reuses one 4-bit
// carry-lookahead slice, one nibble per clock, LSB nibble first.
// Ports: clk, rst (async, active-high), start, a, b, cin,
//        [sub when SERIAL_SUB_EN is defined], busy, done, sum, cout.
// Optional macro SERIAL_SUB_EN adds the sub input (sum = a - b).
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             accept;
   logic             last;

   logic [3:0] sa;
   logic [3:0] sb;
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;
   logic [3:0] s_sum;
   logic       s_cout;

   assign last = (idx == LAST);

   // Current nibble of each operand; {idx,2'b00} is idx*4.
   assign sa = a_reg[{idx, 2'b00} +: 4];
   assign sb = b_reg[{idx, 2'b00} +: 4];

   // 4-bit carry-lookahead slice.
   always_comb begin
      g    = sa & sb;
      p    = sa ^ sb;
      c[0] = carry;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s_sum  = p ^ c[3:0];
      s_cout = c[4];
   end

   // Accumulator with the current nibble merged in, so the final
   // edge can publish the complete result in one step.
   always_comb begin
      acc_nx = acc;
      acc_nx[{idx, 2'b00} +: 4] = s_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_reg <= a;
         idx   <= '0;
`ifdef SERIAL_SUB_EN
         // Subtract as a + ~b + 1; cin has no meaning here.
         b_reg <= sub ? ~b : b;
         carry <= sub ? 1'b1 : cin;
`else
         b_reg <= b;
         carry <= cin;
`endif
      end else if (state == RUN) begin
         acc   <= acc_nx;
         carry <= s_cout;
         if (last) begin
            sum  <= acc_nx;
            cout <= s_cout;
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized self-checking bench for
// nibble_serial_add_ctrl (WIDTH=16) against an arithmetic model.
module tb_nibble_serial_add_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_cmp = 0;
   int n_bad = 0;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
`ifdef SERIAL_SUB_EN
      .sub  (sub),
`endif
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] model(input logic [W-1:0] ma,
                                        input logic [W-1:0] mb,
                                        input logic mc,
                                        input logic ms);
      logic [W:0] r;
      if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
      else    r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
      return r;
   endfunction

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is);
      a = ia;
      b = ib;
      cin = ic;
      sub = is;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts negedges after the accepting edge until done; -1 on timeout.
   task automatic wait_done(output int cyc, output int bcnt);
      cyc = -1;
      bcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done, cout, sum} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle cyc=%0d got busy=%b done=%b cout=%b sum=%h want 0",
                     i, busy, done, cout, sum);
         end
      end
   endtask

   task automatic test_basic;
      int cyc, bc;
      logic [W:0] exp;
      exp = model(16'h1234, 16'h0FCC, 1'b0, 1'b0);
      issue(16'h1234, 16'h0FCC, 1'b0, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== NIB + 1) begin
         n_bad++;
         $display("FAIL basic_latency got %0d want %0d", cyc, NIB + 1);
      end
      n_cmp++;
      if (bc !== NIB) begin
         n_bad++;
         $display("FAIL basic_busy_cycles got %0d want %0d", bc, NIB);
      end
      n_cmp++;
      if ({cout, sum} !== exp || sum !== 16'h2200) begin
         n_bad++;
         $display("FAIL basic_sum got %b_%h want %b_%h", cout, sum, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_carry_ripple;
      int cyc, bc;
      logic [W:0] exp;
      exp = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if ({cout, sum} !== exp || cyc !== NIB + 1) begin
         n_bad++;
         $display("FAIL ripple_sum got %b_%h cyc=%0d want %b_%h cyc=%0d",
                  cout, sum, cyc, exp[W], exp[W-1:0], NIB + 1);
      end
      exp = model(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== NIB + 1) begin
         n_bad++;
         $display("FAIL b2b_latency got %0d want %0d", cyc, NIB + 1);
      end
      n_cmp++;
      if ({cout, sum} !== exp) begin
         n_bad++;
         $display("FAIL b2b_sum got %b_%h want %b_%h", cout, sum, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_ignored_start;
      int ndone;
      logic [W:0] got;
      ndone = 0;
      got = '0;
      issue(16'h0001, 16'h0002, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            got = {cout, sum};
         end
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         start = 1'b0;
         if (i == 2) begin
            a = 16'hAAAA;
            start = 1'b1;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ndone !== 1) begin
         n_bad++;
         $display("FAIL ignored_start_dones got %0d want 1", ndone);
      end
      n_cmp++;
      if (got !== 17'h00003) begin
         n_bad++;
         $display("FAIL ignored_start_sum got %h want 00003", got);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ignored_start_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      int cyc, bc, ndone;
      logic [W:0] exp;
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, cout, sum} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid got busy=%b done=%b cout=%b sum=%h want 0",
                  busy, done, cout, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      n_cmp++;
      if (ndone !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_activity got %0d want 0", ndone);
      end
      exp = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if ({cout, sum} !== exp || cyc !== NIB + 1) begin
         n_bad++;
         $display("FAIL reset_mid_after got %b_%h cyc=%0d want %b_%h",
                  cout, sum, cyc, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_random;
      int cyc, bc, gap;
      logic [W-1:0] ra, rb;
      logic rc;
      logic [W:0] exp;
      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         if (n % 8 == 0) ra = 16'hFFFF;
         exp = model(ra, rb, rc, 1'b0);
         issue(ra, rb, rc, 1'b0);
         a = 16'($urandom);
         b = 16'($urandom);
         wait_done(cyc, bc);
         n_cmp++;
         if ({cout, sum} !== exp || cyc !== NIB + 1) begin
            n_bad++;
            $display("FAIL random_%0d a=%h b=%h c=%b got %b_%h cyc=%0d want %b_%h",
                     n, ra, rb, rc, cout, sum, cyc, exp[W], exp[W-1:0]);
         end
         gap = $urandom_range(0, 3);
         for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({cout, sum} !== exp || busy !== 1'b0 || done !== 1'b0) begin
               n_bad++;
               $display("FAIL random_hold_%0d got %b_%h busy=%b done=%b want %b_%h",
                        n, cout, sum, busy, done, exp[W], exp[W-1:0]);
            end
         end
      end
   endtask

`ifdef SERIAL_SUB_EN
   task automatic test_sub;
      int cyc, bc;
      issue(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if ({cout, sum} !== model(16'h0005, 16'h0007, 1'b0, 1'b1) || sum !== 16'hFFFE) begin
         n_bad++;
         $display("FAIL sub_borrow got %b_%h want 0_fffe", cout, sum);
      end
      issue(16'h0007, 16'h0005, 1'b1, 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if ({cout, sum} !== model(16'h0007, 16'h0005, 1'b1, 1'b1) || sum !== 16'h0002) begin
         n_bad++;
         $display("FAIL sub_noborrow got %b_%h want 1_0002", cout, sum);
      end
      sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_carry_ripple;
      test_ignored_start;
      test_reset_mid;
      test_random;
`ifdef SERIAL_SUB_EN
      test_sub;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
